// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial front end for the serial two's
// complement stage. Accepts a word over valid/ready, issues a one-cycle
// clear pulse to the downstream stage, then shifts the word out LSB-first.
module word_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             stage_rst,
   output logic             word_done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic lastBit;
   logic readyInt;
   logic accept;

   // The last bit cycle doubles as a load slot so words can stream back-to-back.
   assign lastBit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   assign readyInt = (state_q == IDLE) || lastBit;
   assign accept   = load_valid && readyInt;

   // State, shift register and bit counter; all clear immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: capture on a handshake, one clear cycle, then shift.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d = data_in;
               cnt_d   = '0;
               state_d = CLR;
            end
         end
         CLR: begin
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (lastBit) begin
               cnt_d = '0;
               if (accept) begin
                  shreg_d = data_in;
                  state_d = CLR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode from registered state. The state register already sits in
   // IDLE while reset is held, so ready is masked by reset to keep the
   // producer from seeing a ready it cannot use; the downstream clear is
   // likewise forced by reset so that stage stays cleared with this block.
   assign load_ready = readyInt && !rst;
   assign bit_valid  = (state_q == SHIFT);
   assign bit_out    = (state_q == SHIFT) && shreg_q[0];
   assign word_done  = lastBit;
   assign stage_rst  = rst || (state_q == CLR);

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed bench for word_serializer with a bit
// scoreboard and a behavioural model of the downstream serial complementer.
module tb_word_serializer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] data_in;
   logic         load_valid;
   logic         load_ready;
   logic         bit_out;
   logic         bit_valid;
   logic         stage_rst;
   logic         word_done;

   typedef struct packed {
      logic b;
      logic done;
   } sbEntry_t;

   sbEntry_t sbQ[$];

   int checks;
   int failures;

   logic         compSeen;
   logic [W-1:0] compWord;
   logic [2:0]   compIdx;

   word_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .stage_rst  (stage_rst),
      .word_done  (word_done)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream serial two's complementer: copy bits through the first 1,
   // invert the rest; assembles its output word for checking.
   always_ff @(posedge clk or posedge stage_rst) begin
      if (stage_rst) begin
         compSeen <= 1'b0;
         compWord <= '0;
         compIdx  <= '0;
      end else if (bit_valid) begin
         compWord[compIdx] <= compSeen ? ~bit_out : bit_out;
         compSeen          <= compSeen | bit_out;
         compIdx           <= compIdx + 3'd1;
      end
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushWord(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         sbQ.push_back('{b: w[i], done: (i == W - 1)});
      end
   endtask

   // Checks the current cycle's outputs; bit cycles are compared against
   // the scoreboard, non-bit cycles must hold the serial outputs low.
   task automatic checkOutput(input logic expValid, input logic expStageRst, input logic expReady);
      sbEntry_t e;
      checkVal("bit_valid", 32'(bit_valid), 32'(expValid));
      checkVal("stage_rst", 32'(stage_rst), 32'(expStageRst));
      checkVal("load_ready", 32'(load_ready), 32'(expReady));
      if (expValid) begin
         if (sbQ.size() == 0) begin
            checkVal("scoreboard_empty", 32'(1), 32'(0));
         end else begin
            e = sbQ.pop_front();
            checkVal("bit_out", 32'(bit_out), 32'(e.b));
            checkVal("word_done", 32'(word_done), 32'(e.done));
         end
      end else begin
         checkVal("bit_out_idle", 32'(bit_out), 32'(0));
         checkVal("word_done_idle", 32'(word_done), 32'(0));
      end
   endtask

   // Runs one word: optional acceptance from IDLE, the clear cycle, and all
   // bit cycles. noisy offers 8'hAA while not ready; offerNext loads nextW
   // on the last-bit cycle; checkComp verifies the complementer result.
   task automatic applyStimulus(input logic [W-1:0] w, input bit fromIdle, input bit noisy,
                                input bit offerNext, input logic [W-1:0] nextW, input bit checkComp);
      logic [W-1:0] negW;
      if (fromIdle) begin
         checkOutput(1'b0, 1'b0, 1'b1);
         load_valid = 1'b1;
         data_in    = w;
         pushWord(w);
         tick();
      end
      if (noisy) begin
         load_valid = 1'b1;
         data_in    = 8'hAA;
      end else begin
         load_valid = 1'b0;
      end
      checkOutput(1'b0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < W; i++) begin
         checkOutput(1'b1, 1'b0, (i == W - 1));
         if (i == W - 1) begin
            if (offerNext) begin
               load_valid = 1'b1;
               data_in    = nextW;
               pushWord(nextW);
            end else begin
               load_valid = 1'b0;
            end
         end
         tick();
      end
      if (checkComp && !offerNext) begin
         negW = ~w + 8'd1;
         checkVal("complementer_word", 32'(compWord), 32'(negW));
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      load_valid = 1'b0;
      data_in    = '0;

      // Reset values held for two cycles, then release.
      tick();
      checkOutput(1'b0, 1'b1, 1'b0);
      tick();
      checkOutput(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput(1'b0, 1'b0, 1'b1);

      // Single word, chained complementer reads 8'hCC.
      applyStimulus(8'h34, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      checkVal("comp_34_is_CC", 32'(compWord), 32'h0000_00CC);

      // Back-to-back words with no idle cycle between them.
      applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Loads offered while not ready are ignored; AA taken on the last bit.
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
      applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Mid-word asynchronous reset after bit 3.
      checkOutput(1'b0, 1'b0, 1'b1);
      load_valid = 1'b1;
      data_in    = 8'h5A;
      pushWord(8'h5A);
      tick();
      load_valid = 1'b0;
      checkOutput(1'b0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput(1'b1, 1'b0, 1'b0);
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      checkVal("async_bit_valid", 32'(bit_valid), 32'(0));
      checkVal("async_load_ready", 32'(load_ready), 32'(0));
      checkVal("async_word_done", 32'(word_done), 32'(0));
      checkVal("async_stage_rst", 32'(stage_rst), 32'(1));
      sbQ.delete();
      tick();
      checkOutput(1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Boundary words: all zeros and MSB only.
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      checkVal("comp_80_is_80", 32'(compWord), 32'h0000_0080);

      // Block settles back in IDLE with nothing left to emit.
      checkOutput(1'b0, 1'b0, 1'b1);
      checkVal("scoreboard_drained", 32'(sbQ.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
